aftab_booth_controller: RTL and testbench
=========================================

Name: aftab_booth_controller

Overview:
Control FSM for the AFTAB AAU radix-2 Booth multiplier. It sequences the Booth datapath: it loads the multiplicand and multiplier, clears the partial product, and runs exactly `size` add/subtract-and-shift iterations. Each iteration is steered by the datapath's 2-bit Booth code `op`. It sits between the AAU top-level control, which issues `startBooth` and consumes `doneBooth`, and the Booth datapath, which it drives.

Parameters:
size, 33, operand width in bits and the number of Booth iterations; must match the datapath.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
startBooth  input  1  request a multiplication; sampled only in IDLE
op  input  2  Booth code from datapath, {Mr[i], Mr[i-1]}
ldM  output  1  load multiplicand register
ldMr  output  1  parallel-load multiplier shift register
zeroP  output  1  synchronously clear partial-product register
ldP  output  1  load partial-product register (shifted value)
shrMr  output  1  shift multiplier register right by one, taking serial-in from datapath
sel  output  1  1 = P takes shifted add/sub result; 0 = P takes shifted old P
subsel  output  1  1 = subtract M; 0 = add M
doneBooth  output  1  one-cycle pulse: product valid on datapath P
busyBooth  output  1  high in LOAD and RUN

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Binary encoded. Counter `cnt` has width $clog2(size+1).
- Reset (rst=1 at an edge): state goes to IDLE and cnt to 0. This applies in any state, including mid-RUN.
- All outputs are Moore/registered-state decoded, except sel and subsel in RUN, which decode `op` combinationally (`op` is itself a register output).
- In IDLE and DONE, every control output is 0 apart from doneBooth in DONE.
- IDLE:
  - Outputs: all 0.
  - startBooth=1 moves to LOAD; otherwise stay in IDLE.
- LOAD (one cycle):
  - Outputs: ldM=1, ldMr=1, zeroP=1, busyBooth=1.
  - Action: cnt is set to 0.
  - Next state: RUN, unconditionally.
- RUN (exactly `size` cycles):
  - Fixed outputs: ldP=1, shrMr=1, busyBooth=1.
  - op=01: sel=1, subsel=0 (add M).
  - op=10: sel=1, subsel=1 (subtract M).
  - op=00 or 11: sel=0, subsel=0 (shift only).
  - Counting: cnt increments each cycle. When cnt == size-1, the next state is DONE; otherwise stay in RUN.
- DONE (one cycle):
  - Outputs: doneBooth=1, busyBooth=0.
  - Next state: IDLE, unconditionally.
  - The datapath holds P until the next LOAD.
- Latency: startBooth sampled at edge 0 gives LOAD in cycle 1, RUN in cycles 2..size+1, and DONE in cycle size+2 (cycle 35 for size=33).
- startBooth in LOAD, RUN or DONE is ignored; it is not queued. A held-high startBooth restarts from IDLE one cycle after DONE.
- If rst and startBooth are both high, rst wins and the state is IDLE.
- A reset mid-RUN abandons the operation. No doneBooth is produced, and datapath contents are don't-care until the next LOAD.
- ldP and zeroP are never both 1 in the same cycle.
- ldM, ldMr and zeroP are high only in LOAD.
- shrMr and ldP are always asserted together.

Decomposition:
- Package aftab_booth_pkg holds:
  - state encodings BOOTH_IDLE=2'd0, BOOTH_LOAD=2'd1, BOOTH_RUN=2'd2, BOOTH_DONE=2'd3;
  - Booth code constants OP_ADD=2'b01, OP_SUB=2'b10.
- Sub-module aftab_booth_counter: a clearable, enabled up-counter with a terminal-count output at size-1. The FSM instantiates it with clear=LOAD and enable=RUN.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then startBooth=0 for 10 cycles -> every output is 0 in every cycle.
- Latency and pulse: startBooth=1 for 1 cycle, size=33 ->
  - LOAD in cycle 1;
  - ldP and shrMr high in cycles 2–34 (33 cycles);
  - doneBooth=1 only in cycle 35;
  - busyBooth high in cycles 1–34.
- op decode in RUN: force op=01, 10, 00, 11 in successive RUN cycles -> {sel,subsel} = 10, 11, 00, 00 respectively, with ldP=shrMr=1 throughout.
- Integrated multiply with the datapath at size=33:
  - M=7, Mr=-3 -> P = 66-bit -21 (all upper bits 1), sampled at doneBooth;
  - M=-2^31, Mr=-1 -> P = 2^31;
  - M=0, Mr=12345 -> P = 0.
- Reset mid-operation: startBooth at cycle 0, rst=1 at cycle 10 ->
  - state is IDLE at cycle 11;
  - no doneBooth within 40 cycles;
  - a new startBooth then completes normally with doneBooth 35 cycles later.
- Start while busy: startBooth pulses at cycles 0, 5 and 35 -> the cycle-5 pulse is ignored, doneBooth at cycle 35 only, and the cycle-35 pulse is ignored (DONE state).

Source files
------------

// File: rtl/aftab_booth_pkg.sv
// Shared encodings for the AFTAB radix-2 Booth multiplier controller.
package aftab_booth_pkg;

  typedef enum logic [1:0] {
    BOOTH_IDLE = 2'd0,
    BOOTH_LOAD = 2'd1,
    BOOTH_RUN  = 2'd2,
    BOOTH_DONE = 2'd3
  } boothState_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

endpackage

// File: rtl/aftab_booth_counter.sv
// Iteration counter for the Booth controller; flags the last RUN iteration.
module aftab_booth_counter #(
  parameter int size  = 33,
  parameter int CNT_W = $clog2(size + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign terminal = (cnt == CNT_W'(size - 1));

endmodule

// File: rtl/aftab_booth_controller.sv
// Control FSM sequencing the Booth datapath: load, `size` add/sub-and-shift steps, done pulse.
module aftab_booth_controller
  import aftab_booth_pkg::*;
#(
  parameter int size = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startBooth,
  input  logic [1:0] op,
  output logic       ldM,
  output logic       ldMr,
  output logic       zeroP,
  output logic       ldP,
  output logic       shrMr,
  output logic       sel,
  output logic       subsel,
  output logic       doneBooth,
  output logic       busyBooth
);

  boothState_t state;
  logic        lastIter;

  aftab_booth_counter #(.size(size)) counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == BOOTH_LOAD),
    .enable  (state == BOOTH_RUN),
    .terminal(lastIter)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOTH_IDLE;
    end else begin
      case (state)
        BOOTH_IDLE: if (startBooth) state <= BOOTH_LOAD;
        BOOTH_LOAD: state <= BOOTH_RUN;
        BOOTH_RUN:  if (lastIter) state <= BOOTH_DONE;
        BOOTH_DONE: state <= BOOTH_IDLE;
        default:    state <= BOOTH_IDLE;
      endcase
    end
  end

  // Outputs decode the state register; only sel/subsel look at op, which is itself registered.
  always_comb begin
    ldM       = 1'b0;
    ldMr      = 1'b0;
    zeroP     = 1'b0;
    ldP       = 1'b0;
    shrMr     = 1'b0;
    sel       = 1'b0;
    subsel    = 1'b0;
    doneBooth = 1'b0;
    busyBooth = 1'b0;
    case (state)
      BOOTH_LOAD: begin
        ldM       = 1'b1;
        ldMr      = 1'b1;
        zeroP     = 1'b1;
        busyBooth = 1'b1;
      end
      BOOTH_RUN: begin
        ldP       = 1'b1;
        shrMr     = 1'b1;
        busyBooth = 1'b1;
        if (op == OP_ADD) begin
          sel = 1'b1;
        end else if (op == OP_SUB) begin
          sel    = 1'b1;
          subsel = 1'b1;
        end
      end
      BOOTH_DONE: doneBooth = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aftab_booth_controller.sv
// Directed bench for the Booth controller, with a small behavioural Booth datapath for real multiplies.
module tb_aftab_booth_controller;

  logic clk = 1'b0;
  logic rst, startBooth;
  logic [1:0] op, opForce;
  logic ldM, ldMr, zeroP, ldP, shrMr, sel, subsel, doneBooth, busyBooth;
  logic useDp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aftab_booth_controller #(.size(33)) dut (
    .clk(clk), .rst(rst), .startBooth(startBooth), .op(op),
    .ldM(ldM), .ldMr(ldMr), .zeroP(zeroP), .ldP(ldP), .shrMr(shrMr),
    .sel(sel), .subsel(subsel), .doneBooth(doneBooth), .busyBooth(busyBooth)
  );

  // Behavioural radix-2 Booth datapath: A holds the upper half of P, Q the multiplier / lower half.
  logic [32:0] mIn, mrIn, mReg, aReg, qReg, sumV;
  logic        qPrev;
  logic [65:0] pVal;

  always_comb begin
    sumV = aReg;
    if (sel) sumV = subsel ? (aReg - mReg) : (aReg + mReg);
  end

  always @(posedge clk) begin
    if (ldM) mReg <= mIn;
    if (ldMr) begin
      qReg  <= mrIn;
      qPrev <= 1'b0;
    end else if (shrMr) begin
      qReg  <= {sumV[0], qReg[32:1]};
      qPrev <= qReg[0];
    end
    if (zeroP) aReg <= '0;
    else if (ldP) aReg <= {sumV[32], sumV[32:1]};
  end

  assign pVal = {aReg, qReg};
  assign op   = useDp ? {qReg[0], qPrev} : opForce;

  function automatic logic [8:0] outs();
    return {ldM, ldMr, zeroP, ldP, shrMr, sel, subsel, doneBooth, busyBooth};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    tick();
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b expected=%b", outs(), 9'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (outs() !== 9'b0) begin
        errors++;
        $display("FAIL idle_cycle%0d: outputs=%b expected=%b", c, outs(), 9'b0);
      end
    end
  endtask

  task automatic test_latency();
    logic [8:0] exp;
    int ldpCount = 0;
    int doneCount = 0;
    useDp = 1'b0;
    opForce = 2'b00;
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 1) exp = 9'b111000001;
      else if (c <= 34) exp = 9'b000110001;
      else if (c == 35) exp = 9'b000000010;
      else exp = 9'b000000000;
      if (ldP) ldpCount++;
      if (doneBooth) doneCount++;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL latency_cycle%0d: outputs=%b expected=%b", c, outs(), exp);
      end
      if (c < 36) tick();
    end
    checks++;
    if (ldpCount != 33 || doneCount != 1) begin
      errors++;
      $display("FAIL latency_counts: ldP cycles=%0d done pulses=%0d expected 33 and 1", ldpCount, doneCount);
    end
  endtask

  task automatic test_op_decode();
    logic [1:0] ops [4];
    logic [8:0] exps [4];
    bit seen = 0;
    ops = '{2'b01, 2'b10, 2'b00, 2'b11};
    exps = '{9'b000111001, 9'b000111101, 9'b000110001, 9'b000110001};
    useDp = 1'b0;
    opForce = 2'b00;
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      opForce = ops[i];
      #1;
      checks++;
      if (outs() !== exps[i]) begin
        errors++;
        $display("FAIL op_decode_%b: outputs=%b expected=%b", ops[i], outs(), exps[i]);
      end
    end
    opForce = 2'b00;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (doneBooth) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL op_decode_done: doneBooth=0 expected=1 within 40 cycles");
    end
    tick();
  endtask

  task automatic test_multiply(input logic [32:0] m, input logic [32:0] mr,
                               input logic [65:0] expP, input string name);
    int lat = 0;
    bit seen = 0;
    useDp = 1'b1;
    mIn = m;
    mrIn = mr;
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    lat = 1;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (doneBooth) seen = 1;
    end
    checks++;
    if (!seen || lat != 35) begin
      errors++;
      $display("FAIL mul_%s_latency: done seen=%0d at cycle %0d expected cycle 35", name, seen, lat);
    end
    checks++;
    if (pVal !== expP) begin
      errors++;
      $display("FAIL mul_%s_product: P=%h expected=%h", name, pVal, expP);
    end
    tick();
    useDp = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat = 0;
    bit seen = 0;
    useDp = 1'b0;
    opForce = 2'b00;
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    checks++;
    if (outs() !== 9'b000110001) begin
      errors++;
      $display("FAIL midreset_run_cycle10: outputs=%b expected=%b", outs(), 9'b000110001);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== 9'b0) begin
      errors++;
      $display("FAIL midreset_idle: outputs=%b expected=%b", outs(), 9'b0);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (doneBooth || busyBooth) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_quiet: active cycles=%0d expected=0", dones);
    end
    startBooth = 1'b1;
    tick();
    startBooth = 1'b0;
    lat = 1;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (doneBooth) seen = 1;
    end
    checks++;
    if (!seen || lat != 35) begin
      errors++;
      $display("FAIL midreset_restart: done seen=%0d at cycle %0d expected cycle 35", seen, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int doneCycle = -1;
    int doneCount = 0;
    int loadCount = 0;
    useDp = 1'b0;
    opForce = 2'b00;
    for (int c = 0; c <= 45; c++) begin
      startBooth = (c == 0 || c == 5 || c == 35);
      tick();
      if (doneBooth) begin
        doneCount++;
        doneCycle = c + 1;
      end
      if (ldM) loadCount++;
      if (c + 1 == 36) begin
        checks++;
        if (outs() !== 9'b0) begin
          errors++;
          $display("FAIL b2b_after_done: outputs=%b expected=%b", outs(), 9'b0);
        end
      end
    end
    startBooth = 1'b0;
    checks++;
    if (doneCount != 1 || doneCycle != 35) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d last at cycle %0d expected 1 at cycle 35", doneCount, doneCycle);
    end
    checks++;
    if (loadCount != 1) begin
      errors++;
      $display("FAIL b2b_loads: LOAD cycles=%0d expected=1", loadCount);
    end
  endtask

  initial begin
    rst = 1'b1;
    startBooth = 1'b0;
    opForce = 2'b00;
    useDp = 1'b0;
    mIn = '0;
    mrIn = '0;
    test_reset();
    test_latency();
    test_op_decode();
    test_multiply(33'd7, -33'sd3, -66'sd21, "7x-3");
    test_multiply(-33'sd2147483648, -33'sd1, 66'd2147483648, "min_x_-1");
    test_multiply(33'd0, 33'd12345, 66'd0, "0x12345");
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
